// File: rtl/ysyx_22050612_wbu.sv
// Writeback unit: arbitrates EXU/LSU results onto the single register-file write port
// and keeps a per-register busy scoreboard for decode hazard detection.
module ysyx_22050612_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] chk_rs1,
  input  logic [ADDR_WIDTH-1:0] chk_rs2,
  input  logic [ADDR_WIDTH-1:0] chk_rd,
  output logic                  hazard,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  idle,
  output logic                  wb_err
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};
  localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0]       busy_r;
  logic                  last_lsu_r;
  logic                  wb_err_r;
  logic                  wen_r;
  logic [ADDR_WIDTH-1:0] waddr_r;
  logic [DATA_WIDTH-1:0] wdata_r;

  logic                  both_s;
  logic                  exu_xfer_s;
  logic                  lsu_xfer_s;
  logic                  xfer_s;
  logic [ADDR_WIDTH-1:0] sel_rd_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  set_s;
  logic [NREG-1:0]       set_mask_s;
  logic [NREG-1:0]       clr_mask_s;
  logic [NREG-1:0]       busy_next_s;
  logic                  err_s;

  // Round-robin arbitration; under contention the source that did not win last time goes.
  always_comb begin
    both_s    = exu_valid & lsu_valid;
    exu_ready = 1'b1;
    lsu_ready = 1'b1;
    if (!rst_n) begin
      exu_ready = 1'b0;
      lsu_ready = 1'b0;
    end else if (both_s) begin
      exu_ready = last_lsu_r;
      lsu_ready = ~last_lsu_r;
    end else begin
      exu_ready = 1'b1;
      lsu_ready = 1'b1;
    end
  end

  // Transfer detection and result selection.
  always_comb begin
    exu_xfer_s = exu_valid & exu_ready;
    lsu_xfer_s = lsu_valid & lsu_ready;
    xfer_s     = exu_xfer_s | lsu_xfer_s;
    sel_rd_s   = lsu_xfer_s ? lsu_rd : exu_rd;
    sel_data_s = lsu_xfer_s ? lsu_data : exu_data;
  end

  // Scoreboard next state: clear on commit, set on issue (set wins), x0 never busy.
  always_comb begin
    set_s       = issue_valid & (issue_rd != ZERO_IDX);
    set_mask_s  = {{(NREG-1){1'b0}}, set_s} << issue_rd;
    clr_mask_s  = {{(NREG-1){1'b0}}, wen_r} << waddr_r;
    busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~X0_MASK;
    err_s = (xfer_s & (sel_rd_s != ZERO_IDX) & ~busy_r[sel_rd_s]
             & ~(set_s & (issue_rd == sel_rd_s)))
          | (set_s & busy_r[issue_rd] & ~(wen_r & (waddr_r == issue_rd)));
  end

  // State registers: commit port, scoreboard, arbitration history and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r     <= {NREG{1'b0}};
      last_lsu_r <= 1'b0;
      wb_err_r   <= 1'b0;
      wen_r      <= 1'b0;
      waddr_r    <= ZERO_IDX;
      wdata_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      busy_r   <= busy_next_s;
      wb_err_r <= wb_err_r | err_s;
      wen_r    <= xfer_s & (sel_rd_s != ZERO_IDX);
      if (xfer_s) begin
        waddr_r    <= sel_rd_s;
        wdata_r    <= sel_data_s;
        last_lsu_r <= lsu_xfer_s;
      end else begin
        waddr_r    <= waddr_r;
        wdata_r    <= wdata_r;
        last_lsu_r <= last_lsu_r;
      end
    end
  end

  assign wen    = wen_r;
  assign waddr  = waddr_r;
  assign wdata  = wdata_r;
  assign wb_err = wb_err_r;
  assign hazard = busy_r[chk_rs1] | busy_r[chk_rs2] | busy_r[chk_rd];
  assign idle   = ~(|busy_r) & ~wen_r;

endmodule

// File: doc/ysyx_22050612_wbu.md
# ysyx_22050612_wbu

Writeback unit for the NPC core. It sits directly upstream of the register file and arbitrates completed results from the EXU (ALU/CSR results) and the LSU (load data) onto the register file's single write port. It also keeps a per-register scoreboard so decode can stall on read-after-write and write-after-write hazards. One result is committed per cycle; the register-file write port is driven from registered outputs.

## Interface
- ADDR_WIDTH, 5, register index width; the scoreboard has 2**ADDR_WIDTH entries.
- DATA_WIDTH, 64, result data width.

- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- exu_valid  in  1  EXU result present.
- exu_ready  out  1  EXU result accepted this cycle when exu_valid is also high.
- exu_rd  in  ADDR_WIDTH  EXU destination register.
- exu_data  in  DATA_WIDTH  EXU result.
- lsu_valid, lsu_ready, lsu_rd, lsu_data  same as the EXU group, for load results.
- issue_valid  in  1  decode issues an instruction that writes issue_rd.
- issue_rd  in  ADDR_WIDTH  destination of the issued instruction.
- chk_rs1, chk_rs2, chk_rd  in  ADDR_WIDTH  decode operands to check.
- hazard  out  1  combinational: busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd].
- wen  out  1  registered write enable to the register file.
- waddr  out  ADDR_WIDTH  registered write address.
- wdata  out  DATA_WIDTH  registered write data.
- idle  out  1  combinational: no busy bit set and wen low.
- wb_err  out  1  sticky error flag; see Operation.

## Operation
- Handshake: a source transfers when valid && ready on a posedge. A source holds valid, rd and data stable until accepted. Ready depends combinationally only on the two valids and last_grant, never on itself.
- Arbitration:
  - Only one source valid: that source is granted.
  - Both valid: the source not in last_grant is granted; the other sees ready = 0.
  - last_grant updates only on a transfer.
  - Neither valid: both ready signals are high (idle-ready).
- Commit register: on a transfer, at the next edge waddr <= rd and wdata <= data. wen <= (rd != 0). With no transfer, wen <= 0 and waddr/wdata hold.
- Writes to x0 are accepted and consumed. They never raise wen and never touch the scoreboard.
- Scoreboard: busy[0..2**ADDR_WIDTH-1], busy[0] is hardwired 0.
  - Set: issue_valid && issue_rd != 0 sets busy[issue_rd] at the edge.
  - Clear: wen high clears busy[waddr] at the same edge the register file writes. Decode therefore sees hazard drop in the first cycle the register file holds the new value.
  - Set and clear on the same index in the same edge: set wins. The newer instruction owns the register.
- Decode must not assert issue_valid while hazard is high. The unit does not gate issue itself.
- wb_err is set, and stays set until reset, in either case:
  - a transfer with rd != 0 whose busy[rd] is 0 and is not being set by the same-edge issue;
  - issue_valid with issue_rd != 0 and busy[issue_rd] already 1 and not being cleared this edge.
  - Neither condition blocks the transfer.
- Reset (any cycle, including mid-transfer): busy all 0, wen 0, waddr 0, wdata 0, last_grant = EXU (so LSU wins the first contention), wb_err 0. Reset overrides any same-edge transfer or issue. While rst_n is low, exu_ready and lsu_ready are 0.

## Timing
- Latency: a transfer at edge N gives wen/waddr/wdata valid during cycle N..N+1. The register file writes at edge N+1, and busy[rd] clears at edge N+1.
- Throughput: one commit per cycle. Back-to-back transfers from one source produce consecutive wen cycles.
- Contention: with both sources continuously valid, grants alternate every cycle. The maximum wait for either source is one cycle.
- hazard and idle are combinational from registered state and the chk_* inputs. There is no path from exu_valid/lsu_valid to hazard.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with exu_valid = 1 -> exu_ready = 0, wen = 0, waddr = 0, wdata = 0, wb_err = 0, idle = 1.
- Single EXU commit:
  - Stimulus: issue rd = 5; next cycle exu_valid, rd = 5, data = 0x1234 accepted at edge N.
  - Required: hazard high for chk_rs1 = 5 until edge N+1; wen = 1, waddr = 5, wdata = 0x1234 in cycle N+1 only; idle = 1 afterwards.
- Contention:
  - Stimulus: after reset, EXU (rd = 3) and LSU (rd = 4) both valid and held.
  - Required: LSU granted first (lsu_ready = 1, exu_ready = 0), EXU the next cycle; waddr sequence 4 then 3.
- x0 write: EXU rd = 0, data = 0xFFFF -> exu_ready = 1; wen stays 0; busy unchanged; wb_err = 0.
- Set/clear collision: busy[7] = 1 with a commit to rd = 7 (wen = 1), and issue_rd = 7 in the same cycle -> busy[7] remains 1 after the edge; wb_err = 0.
- Error and reset mid-operation:
  - Stimulus: LSU commits rd = 9 with busy[9] = 0.
  - Required: wb_err = 1 and stays 1.
  - Stimulus: pull rst_n low during a pending EXU transfer.
  - Required: the next cycle shows wen = 0, busy all clear, wb_err = 0.
